// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and alignment check for the load/store unit
package lsu_pkg;
  localparam int LSU_XLEN = 32;
  localparam int BYTES = LSU_XLEN / 8;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_size_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_t;
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return (size == 3'b011) || (size[2:1] == 2'b11) ||
           (size[1:0] == 2'b01 && lo[0]) || (size == 3'b010 && lo != 2'b00);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero-extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] rdata,
  input  logic [1:0]          addr,
  input  logic [2:0]          size,
  output logic [LSU_XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = (size == LB)  ? {{24{b[7]}}, b} :
           (size == LBU) ? {24'b0, b} :
           (size == LH)  ? {{16{h[15]}}, h} :
           (size == LHU) ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word memory-access stage with misalignment exceptions
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_size,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH/8-1:0]   dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      st_done,
  output logic                      exc_valid,
  output logic [ADDR_WIDTH-1:0]     exc_addr,
  output logic                      exc_store
);
  lsu_state_t                state, state_next;
  logic                      q_we;
  logic [2:0]                q_size;
  logic [1:0]                q_lo;
  logic [REG_ADDR_WIDTH-1:0] q_rd;
  logic                      accept, bad;
  logic [BYTES-1:0]          be_next;
  logic [DATA_WIDTH-1:0]     wdata_next, ld_data;
  load_align u_align (
    .rdata(dmem_rdata),
    .addr (q_lo),
    .size (q_size),
    .data (ld_data)
  );
  always_comb begin
    req_ready = rst_n && state == IDLE;
    accept = req_valid && req_ready;
    bad = misaligned(req_size, req_addr[1:0]);
    be_next = (req_size[1:0] == 2'b00) ? 4'b0001 << req_addr[1:0] :
              (req_size[1:0] == 2'b01) ? 4'b0011 << req_addr[1:0] : 4'b1111;
    wdata_next = (req_size[1:0] == 2'b00) ? {4{req_wdata[7:0]}} :
                 (req_size[1:0] == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
    dmem_req_valid = state == REQ;
    dmem_we = state == REQ && q_we;
    state_next = state;
    if (state == IDLE && accept && !bad) state_next = REQ;
    if (state == REQ && dmem_req_ready) state_next = q_we ? IDLE : RSP;
    if (state == RSP && dmem_rsp_valid) state_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q_we <= 1'b0;
      q_size <= 3'b0;
      q_lo <= 2'b0;
      q_rd <= '0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      st_done <= 1'b0;
      exc_valid <= 1'b0;
      exc_addr <= '0;
      exc_store <= 1'b0;
    end else begin
      state <= state_next;
      wb_valid <= 1'b0;
      st_done <= 1'b0;
      exc_valid <= 1'b0;
      if (accept) begin
        q_we <= req_we;
        q_size <= req_size;
        q_lo <= req_addr[1:0];
        q_rd <= req_rd;
        dmem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        dmem_be <= be_next;
        dmem_wdata <= wdata_next;
        if (bad) begin
          exc_valid <= 1'b1;
          exc_addr <= req_addr;
          exc_store <= req_we;
        end
      end
      if (state == REQ && dmem_req_ready && q_we) st_done <= 1'b1;
      if (state == RSP && dmem_rsp_valid) begin
        wb_valid <= 1'b1;
        wb_data <= ld_data;
        wb_rd <= q_rd;
      end
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU in the core's execute path. It takes the ALU result as an effective address, issues RV32I loads and stores (byte/half/word) to the data-memory port over a valid/ready handshake, and returns sign- or zero-extended load data to writeback. Misaligned accesses never reach memory; they raise a one-cycle exception pulse instead.

## Interface
- `ADDR_WIDTH`, default 32: effective address width.
- `DATA_WIDTH`, default 32: data width; only 32 is supported.
- `REG_ADDR_WIDTH`, default 5: destination register index width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- `req_addr`  in  ADDR_WIDTH  effective address (ALU `opr_result`).
- `req_wdata`  in  DATA_WIDTH  store data (rs2), right-aligned.
- `req_rd`  in  REG_ADDR_WIDTH  load destination.
- `dmem_req_valid`  out  1  memory request.
- `dmem_req_ready`  in  1  memory accepts request.
- `dmem_we`  out  1  write strobe.
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address (low 2 bits zero).
- `dmem_be`  out  DATA_WIDTH/8  byte enables.
- `dmem_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `dmem_rsp_valid`  in  1  read data valid.
- `dmem_rdata`  in  DATA_WIDTH  raw word.
- `wb_valid`  out  1  one-cycle load-result pulse.
- `wb_rd`  out  REG_ADDR_WIDTH  load destination.
- `wb_data`  out  DATA_WIDTH  extended load data.
- `st_done`  out  1  one-cycle store-completion pulse.
- `exc_valid`  out  1  one-cycle misaligned pulse.
- `exc_addr`  out  ADDR_WIDTH  faulting address.
- `exc_store`  out  1  1 = store fault.

## Operation
- FSM states IDLE, REQ, RSP.
- IDLE: a request is accepted when `req_valid & req_req_ready`. All request fields are captured into registers at acceptance.
  - Misaligned case: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. `exc_valid`, `exc_addr` and `exc_store` are registered, the unit stays in IDLE, and no memory access is made.
  - Illegal `req_size` (011, 110, 111): treated as misaligned.
  - Otherwise go to REQ.
- REQ: `dmem_req_valid`=1, and address, byte enables and write data are held stable until `dmem_req_ready`.
  - On handshake, a store goes to IDLE and pulses `st_done` next cycle.
  - On handshake, a load goes to RSP.
- RSP: wait for `dmem_rsp_valid`, then select the lane by `addr[1:0]` and extend.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register `wb_data`/`wb_rd` and pulse `wb_valid`; go to IDLE.
- Byte enables: byte `0001<<a[1:0]`; half `0011<<a[1:0]`; word `1111`.
- Store data: replicate the byte into all lanes for SB; replicate the half into both halves for SH.
- `dmem_rsp_valid` outside RSP is ignored.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there, so the producer holds.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0, 1 after (IDLE). Every other output is 0, including `wb_data`, `exc_addr` and `dmem_*`.
- Request accepted at edge T → `dmem_req_valid` high in cycle T+1.
- Store: handshake at edge H → `st_done` in cycle H+1, `req_ready` high in cycle H+1. Best case is 2 cycles per store.
- Load: response at edge R → `wb_valid` in cycle R+1, `req_ready` high in cycle R+1. With a zero-wait memory, the best case is 3 cycles per load.
- Misaligned: accepted at T → `exc_valid` in cycle T+1. Back-to-back accepts are allowed.
- `wb_valid`, `st_done` and `exc_valid` are exactly one cycle wide and never coincide.
- Reset asserted mid-transaction: the FSM is IDLE on the next edge, `dmem_req_valid` drops, and a later stray response is ignored.

## Structure
- Shared `lsu_pkg`:
  - `lsu_size_t` enum (LB, LH, LW, LBU, LHU).
  - `lsu_state_t` (IDLE, REQ, RSP).
  - `BYTES = DATA_WIDTH/8`.
- One combinational sub-module, `load_align`: inputs `rdata`, `addr[1:0]`, `size`; output the extended result. Byte-enable and store-lane generation stay inline.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, `dmem_req_ready` tied 1 → `dmem_addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF, `st_done` 2 cycles after accept.
- SB addr 0x203, data 0x000000A5 → `dmem_addr`=0x200, `be`=1000, `wdata`=0xA5A5A5A5.
- LB addr 0x102, rdata 0x0080FF00, rd=7 → `wb_data`=0xFFFFFF80, `wb_rd`=7. Repeat as LBU → `wb_data`=0x00000080.
- LH addr 0x102, rdata 0x8001_1234 → `wb_data`=0xFFFF8001; LHU → 0x00008001.
- LW addr 0x101 → `exc_valid` 1 cycle, `exc_addr`=0x101, `exc_store`=0, `dmem_req_valid` never asserts.
- LW with `dmem_req_ready` held low 3 cycles, then `rst_n` low during RSP → `dmem` signals stable while stalled; after reset, `req_ready`=1 and a stray `dmem_rsp_valid` produces no `wb_valid`.
